// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch sequencer: state encodings,
// default reset/exception addresses and the instruction width.
package fetch_ctrl_pkg;

   localparam int unsigned InstrWidth = 32;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Priority select of the PC register's next value and write enable:
// exception > eret > branch/jump > sequential pc+4.
module fetch_redirect_mux
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic        exc_req,
   input  logic        eret,
   input  logic        br_taken,
   input  logic [31:0] epc,
   input  logic [31:0] br_target,
   input  logic [31:0] pc_addr,
   input  logic        seq_adv,
   output logic [31:0] next_pc,
   output logic        pc_en,
   output logic        redir
);

   always_comb begin
      redir   = exc_req | eret | br_taken;
      next_pc = pc_addr + 32'd4;
      if (exc_req) begin
         next_pc = EXC_VECTOR;
      end else if (eret) begin
         next_pc = epc;
      end else if (br_taken) begin
         next_pc = br_target;
      end
      pc_en = redir | seq_adv;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: req/ack fetch into a one-entry IF/ID buffer
// with redirect handling. Define FETCH_EXC_EN to enable exc_req/eret redirects.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [31:0]           pc_addr,
   output logic [31:0]           next_pc,
   output logic                  pc_en,
   input  logic                  stall,
   input  logic                  br_taken,
   input  logic [31:0]           br_target,
   input  logic                  exc_req,
   input  logic                  eret,
   input  logic [31:0]           epc,
   output logic                  im_req,
   output logic [31:0]           im_addr,
   input  logic                  im_ack,
   input  logic [InstrWidth-1:0] im_rdata,
   output logic                  if_valid,
   output logic [InstrWidth-1:0] if_instr,
   output logic [31:0]           if_pc
);

   logic [1:0]            state, state_d;
   logic [31:0]           im_addr_d, if_pc_d;
   logic [InstrWidth-1:0] if_instr_d;
   logic                  if_valid_d;
   logic                  exc_g, eret_g, redir, seq_adv;

`ifdef FETCH_EXC_EN
   assign exc_g  = exc_req;
   assign eret_g = eret;
`else
   assign exc_g  = 1'b0;
   assign eret_g = 1'b0;
   logic unused_exc;
   assign unused_exc = exc_req ^ eret;
`endif

   // A redirect in the ack cycle suppresses the sequential advance inside the mux.
   assign seq_adv = (state == ST_REQ) & im_ack;
   assign im_req  = (state == ST_REQ) | (state == ST_DRAIN);

   fetch_redirect_mux #(
      .EXC_VECTOR(EXC_VECTOR)
   ) u_redirect_mux (
      .exc_req  (exc_g),
      .eret     (eret_g),
      .br_taken (br_taken),
      .epc      (epc),
      .br_target(br_target),
      .pc_addr  (pc_addr),
      .seq_adv  (seq_adv),
      .next_pc  (next_pc),
      .pc_en    (pc_en),
      .redir    (redir)
   );

   always_comb begin
      state_d    = state;
      im_addr_d  = im_addr;
      if_valid_d = if_valid;
      if_instr_d = if_instr;
      if_pc_d    = if_pc;
      case (state)
         ST_LOAD: begin
            im_addr_d = pc_addr;
            if (!redir) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (redir) begin
               state_d = im_ack ? ST_LOAD : ST_DRAIN;
            end else if (im_ack) begin
               if_instr_d = im_rdata;
               if_pc_d    = im_addr;
               if_valid_d = 1'b1;
               state_d    = ST_FULL;
            end
         end
         ST_FULL: begin
            if (redir || !stall) begin
               if_valid_d = 1'b0;
               state_d    = ST_LOAD;
            end
         end
         default: begin
            // Wait out the cancelled request; its data is never captured.
            if (!redir && im_ack) state_d = ST_LOAD;
         end
      endcase
      if (redir) if_valid_d = 1'b0;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= ST_LOAD;
         im_addr  <= RESET_PC;
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc    <= '0;
      end else begin
         state    <= state_d;
         im_addr  <= im_addr_d;
         if_valid <= if_valid_d;
         if_instr <= if_instr_d;
         if_pc    <= if_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl; the PC register is modelled inside the tick task.
module tb_fetch_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] pc_addr, next_pc, br_target, epc, im_addr, im_rdata, if_instr, if_pc;
   logic        pc_en, stall, br_taken, exc_req, eret, im_req, im_ack, if_valid;

   int nvec = 0;
   int nerr = 0;

   always #5 Clk = ~Clk;

   fetch_ctrl dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .pc_addr  (pc_addr),
      .next_pc  (next_pc),
      .pc_en    (pc_en),
      .stall    (stall),
      .br_taken (br_taken),
      .br_target(br_target),
      .exc_req  (exc_req),
      .eret     (eret),
      .epc      (epc),
      .im_req   (im_req),
      .im_addr  (im_addr),
      .im_ack   (im_ack),
      .im_rdata (im_rdata),
      .if_valid (if_valid),
      .if_instr (if_instr),
      .if_pc    (if_pc)
   );

   // One clock: PC register model loads next_pc when pc_en was high before the edge.
   task automatic tick();
      logic        en;
      logic [31:0] np;
      en = pc_en;
      np = next_pc;
      @(posedge Clk);
      #1;
      if (Reset) pc_addr = 32'h3000;
      else if (en) pc_addr = np;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; pc_addr = 32'h3000; stall = 0; br_taken = 0; br_target = 0;
      exc_req = 0; eret = 0; epc = 0; im_ack = 0; im_rdata = 0;
      repeat (2) @(posedge Clk);
      #1; settle();
      nvec++; if (if_valid !== 1'b0) begin nerr++; $display("FAIL reset_if_valid got %h want 0", if_valid); end
      nvec++; if (im_req !== 1'b0) begin nerr++; $display("FAIL reset_im_req got %h want 0", im_req); end
      nvec++; if (im_addr !== 32'h3000) begin nerr++; $display("FAIL reset_im_addr got %h want 3000", im_addr); end
      nvec++; if (pc_en !== 1'b0) begin nerr++; $display("FAIL reset_pc_en got %h want 0", pc_en); end
      nvec++; if ({if_instr, if_pc} !== 64'h0) begin nerr++; $display("FAIL reset_buf got %h/%h want 0/0", if_instr, if_pc); end
      Reset = 1'b0;
      tick(); settle();
      nvec++; if (im_req !== 1'b1 || im_addr !== 32'h3000) begin
         nerr++; $display("FAIL first_req got req=%h addr=%h want 1/3000", im_req, im_addr); end
   endtask

   task automatic test_first_fetch();
      im_ack = 1; im_rdata = 32'hA000_0001; settle();
      nvec++; if (pc_en !== 1'b1 || next_pc !== 32'h3004) begin
         nerr++; $display("FAIL ack_pc got en=%h np=%h want 1/3004", pc_en, next_pc); end
      tick();
      im_ack = 0; stall = 1; settle();
      nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h3000 || if_instr !== 32'hA000_0001) begin
         nerr++; $display("FAIL first_buf got v=%h pc=%h i=%h want 1/3000/a0000001", if_valid, if_pc, if_instr); end
      nvec++; if (pc_addr !== 32'h3004) begin nerr++; $display("FAIL pc_reg got %h want 3004", pc_addr); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) begin
         nvec++; if (if_valid !== 1'b1 || if_instr !== 32'hA000_0001 || im_req !== 1'b0 || pc_en !== 1'b0) begin
            nerr++; $display("FAIL stall_hold[%0d] got v=%h i=%h req=%h en=%h want 1/a0000001/0/0",
                             i, if_valid, if_instr, im_req, pc_en); end
         tick(); settle();
      end
      stall = 0; settle();
      tick(); settle();
      nvec++; if (if_valid !== 1'b0 || im_req !== 1'b0) begin
         nerr++; $display("FAIL consume_load got v=%h req=%h want 0/0", if_valid, im_req); end
      tick(); settle();
      nvec++; if (im_req !== 1'b1 || im_addr !== 32'h3004) begin
         nerr++; $display("FAIL seq_req got req=%h addr=%h want 1/3004", im_req, im_addr); end
   endtask

   task automatic test_branch_drain();
      br_taken = 1; br_target = 32'h3100; settle();
      nvec++; if (pc_en !== 1'b1 || next_pc !== 32'h3100) begin
         nerr++; $display("FAIL br_pc got en=%h np=%h want 1/3100", pc_en, next_pc); end
      tick();
      br_taken = 0; settle();
      for (int i = 0; i < 2; i++) begin
         nvec++; if (im_req !== 1'b1 || im_addr !== 32'h3004 || if_valid !== 1'b0) begin
            nerr++; $display("FAIL drain_hold[%0d] got req=%h addr=%h v=%h want 1/3004/0", i, im_req, im_addr, if_valid); end
         tick(); settle();
      end
      im_ack = 1; im_rdata = 32'hDEAD_BEEF; settle();
      nvec++; if (pc_en !== 1'b0) begin nerr++; $display("FAIL drain_ack_en got %h want 0", pc_en); end
      tick();
      im_ack = 0; settle();
      nvec++; if (if_valid !== 1'b0 || im_req !== 1'b0) begin
         nerr++; $display("FAIL drain_discard got v=%h req=%h want 0/0", if_valid, im_req); end
      tick(); settle();
      nvec++; if (im_req !== 1'b1 || im_addr !== 32'h3100) begin
         nerr++; $display("FAIL br_req got req=%h addr=%h want 1/3100", im_req, im_addr); end
   endtask

   task automatic test_coincident();
      im_ack = 1; im_rdata = 32'hBAD0_0002; br_taken = 1; br_target = 32'h3200; settle();
      nvec++; if (pc_en !== 1'b1 || next_pc !== 32'h3200) begin
         nerr++; $display("FAIL coin_pc got en=%h np=%h want 1/3200", pc_en, next_pc); end
      tick();
      im_ack = 0; br_taken = 0; settle();
      nvec++; if (if_valid !== 1'b0 || im_req !== 1'b0) begin
         nerr++; $display("FAIL coin_load got v=%h req=%h want 0/0", if_valid, im_req); end
      tick(); settle();
      nvec++; if (im_req !== 1'b1 || im_addr !== 32'h3200) begin
         nerr++; $display("FAIL coin_req got req=%h addr=%h want 1/3200", im_req, im_addr); end
   endtask

   task automatic test_priority();
      exc_req = 1; eret = 1; epc = 32'h3008; br_taken = 1; br_target = 32'h3500; settle();
`ifdef FETCH_EXC_EN
      nvec++; if (pc_en !== 1'b1 || next_pc !== 32'h4180) begin
         nerr++; $display("FAIL prio_exc got en=%h np=%h want 1/4180", pc_en, next_pc); end
      exc_req = 0; br_taken = 0; settle();
      nvec++; if (pc_en !== 1'b1 || next_pc !== 32'h3008) begin
         nerr++; $display("FAIL prio_eret got en=%h np=%h want 1/3008", pc_en, next_pc); end
      eret = 0; settle();
`else
      nvec++; if (pc_en !== 1'b1 || next_pc !== 32'h3500) begin
         nerr++; $display("FAIL prio_br got en=%h np=%h want 1/3500", pc_en, next_pc); end
      eret = 0; br_taken = 0; settle();
      nvec++; if (pc_en !== 1'b0) begin nerr++; $display("FAIL exc_ignored got en=%h want 0", pc_en); end
`endif
      im_ack = 1; im_rdata = 32'hC000_0003; settle();
      nvec++; if (pc_en !== 1'b1 || next_pc !== 32'h3204) begin
         nerr++; $display("FAIL seq_after got en=%h np=%h want 1/3204", pc_en, next_pc); end
      tick();
      im_ack = 0; exc_req = 0; stall = 1; settle();
      nvec++; if (if_valid !== 1'b1 || if_pc !== 32'h3200 || if_instr !== 32'hC000_0003) begin
         nerr++; $display("FAIL buf3 got v=%h pc=%h i=%h want 1/3200/c0000003", if_valid, if_pc, if_instr); end
   endtask

   task automatic test_back_to_back();
      stall = 0; br_taken = 1; br_target = 32'h3300; settle();
      nvec++; if (pc_en !== 1'b1 || next_pc !== 32'h3300) begin
         nerr++; $display("FAIL full_br got en=%h np=%h want 1/3300", pc_en, next_pc); end
      tick();
      br_taken = 0; settle();
      nvec++; if (if_valid !== 1'b0 || im_req !== 1'b0) begin
         nerr++; $display("FAIL full_br_load got v=%h req=%h want 0/0", if_valid, im_req); end
      tick(); settle();
      nvec++; if (im_req !== 1'b1 || im_addr !== 32'h3300) begin
         nerr++; $display("FAIL full_br_req got req=%h addr=%h want 1/3300", im_req, im_addr); end
   endtask

   task automatic test_reset_midfetch();
      #2; Reset = 1; pc_addr = 32'h3000; #1;
      nvec++; if (im_req !== 1'b0 || im_addr !== 32'h3000 || if_valid !== 1'b0) begin
         nerr++; $display("FAIL async_reset got req=%h addr=%h v=%h want 0/3000/0", im_req, im_addr, if_valid); end
      tick();
      Reset = 0; settle();
      tick(); settle();
      nvec++; if (im_req !== 1'b1 || im_addr !== 32'h3000) begin
         nerr++; $display("FAIL rst_req got req=%h addr=%h want 1/3000", im_req, im_addr); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_stall();
      test_branch_drain();
      test_coincident();
      test_priority();
      test_back_to_back();
      test_reset_midfetch();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined CPU.
- Drives the PC register's next-PC value and write-enable.
- Issues variable-latency requests to instruction memory over a req/ack handshake and holds each fetched word in a one-entry buffer for the IF/ID stage.
- Applies redirects from branch/jump, exception and eret, and cancels any fetch still in flight.

Parameters:
- RESET_PC, 32'h00003000, PC value after reset. Must match the PC register reset value.
- EXC_VECTOR, 32'h00004180, exception entry address.

Ports:
- Clk  in  1  clock
- Reset  in  1  reset, asynchronous, active-high
- pc_addr  in  32  current PC register output
- next_pc  out  32  PC register next value (combinational)
- pc_en  out  1  PC register write enable (combinational)
- stall  in  1  hazard unit holds IF/ID
- br_taken  in  1  branch/jump redirect
- br_target  in  32  branch/jump target
- exc_req  in  1  exception redirect
- eret  in  1  return from exception
- epc  in  32  eret target
- im_req  out  1  instruction memory request
- im_addr  out  32  request address (registered)
- im_ack  in  1  memory data valid
- im_rdata  in  32  instruction word
- if_valid  out  1  buffer holds a valid instruction
- if_instr  out  32  buffered instruction
- if_pc  out  32  PC of the buffered instruction

Behaviour:
- Reset (Reset is asynchronous, active-high; Clk is the clock):
  - state=LOAD; if_valid=0; im_addr=RESET_PC.
  - if_instr=0, if_pc=0, drop flag=0.
  - pc_en=0 (combinational, no redirect pending).
- FSM states: LOAD, REQ, FULL, DRAIN.
  - LOAD: im_req=0. im_addr <= pc_addr. Go to REQ.
  - REQ: im_req=1, im_addr held stable. On im_ack:
    - if_instr <= im_rdata; if_pc <= im_addr; if_valid <= 1.
    - pc_en=1, next_pc=pc_addr+4 (mod 2^32).
    - Go to FULL.
    - With no im_ack, stay in REQ.
  - FULL: im_req=0. The instruction is consumed in any cycle with !stall: if_valid <= 0, go to LOAD. If stall, hold.
  - DRAIN: im_req=1 with the old im_addr until im_ack. The returned data is discarded; then go to LOAD.
- Redirect:
  - redir = exc_req | eret | br_taken.
  - Priority: exc_req (EXC_VECTOR) > eret (epc) > br_taken (br_target).
  - In any cycle with redir: pc_en=1 and next_pc=the selected target. This overrides the sequential +4 and ignores stall.
  - The same cycle: if_valid <= 0 next edge.
  - Next state by current state:
    - REQ without im_ack → DRAIN.
    - REQ with im_ack → data discarded, → LOAD.
    - FULL → LOAD.
    - DRAIN → stays DRAIN.
    - LOAD → stays LOAD. im_addr latches the pre-redirect pc this edge; LOAD is re-entered so the new pc is latched next.
- pc_en=0 in all other cycles. The PC holds.
- Latency: reset release → first im_req 1 cycle. Best-case ack (1 cycle after req) → if_valid 1 cycle later. Sequential throughput: one instruction per (ack latency + 2) cycles.
- Handshake: im_req never drops and im_addr never changes before im_ack. im_ack while im_req=0 is ignored.
- Reset mid-fetch: the outstanding request is abandoned. The memory model is reset on the same Reset.
- Simultaneous consume and redirect in FULL: the redirect wins and the result is identical to the consume path.

Optional Feature:
- Macro FETCH_EXC_EN.
- Defined: exc_req/eret/epc are active as above.
- Undefined: exc_req and eret are ignored; only br_taken can redirect; ports remain present.

Decomposition:
- Shared package: the 2-bit state encodings (LOAD=0, REQ=1, FULL=2, DRAIN=3), RESET_PC and EXC_VECTOR defaults, and the instruction width constant.
- Natural sub-module: fetch_redirect_mux. Combinational priority select of next_pc/pc_en from the redirect sources and pc_addr+4.

Test Plan:
- Reset, memory ack latency 1 → im_req rises 1 cycle after release with im_addr=0x3000. if_valid=1, if_pc=0x3000 on the cycle after ack; pc_en pulses with next_pc=0x3004.
- stall=1 held 5 cycles in FULL → if_valid/if_instr stable, im_req=0, pc_en=0. Release → LOAD, then im_addr=0x3004.
- br_taken with target 0x3100 in REQ, ack 3 cycles later → DRAIN. Old data discarded (if_valid stays 0). Next request im_addr=0x3100.
- exc_req, eret and br_taken in the same cycle → next_pc=0x4180. Then eret alone with epc=0x3008 → next_pc=0x3008.
- Redirect coincident with im_ack in REQ → no if_valid. Next im_addr=target.
- FETCH_EXC_EN undefined: exc_req=1 alone → pc_en=0 and fetch continues sequentially.
